// File: rtl/rf_pkg.sv
// Shared register-file write-path constants and request record.
package rf_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGS      = 2 ** ADDRESS_WIDTH;

    // x0 is hardwired to zero: writes to it are consumed but never issued.
    localparam logic [ADDRESS_WIDTH-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations plus decode hazard check.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
    parameter int NUM_REGS      = 2 ** ADDRESS_WIDTH
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     iSetEn,
    input  logic [ADDRESS_WIDTH-1:0] iSetAddr,
    input  logic                     iClrEn,
    input  logic [ADDRESS_WIDTH-1:0] iClrAddr,
    input  logic [ADDRESS_WIDTH-1:0] iDecRs1,
    input  logic [ADDRESS_WIDTH-1:0] iDecRs2,
    input  logic [ADDRESS_WIDTH-1:0] iDecRd,
    input  logic                     iDecRdUsed,
    output logic                     oStall,
    output logic [NUM_REGS-1:0]      oPending
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Next pending vector: clear then set, so a same-cycle set on the same rd wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iSetEn && (iSetAddr != '0)) set_mask[iSetAddr] = 1'b1;
        if (iClrEn)                     clr_mask[iClrAddr] = 1'b1;
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // RAW on either source or WAW on the destination holds decode.
    always_comb begin
        oStall = ((iDecRs1 != '0) && pending_q[iDecRs1]) ||
                 ((iDecRs2 != '0) && pending_q[iDecRs2]) ||
                 (iDecRdUsed && pending_q[iDecRd]);
    end

    assign oPending = pending_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between writeback and a buffered
// long-latency producer, with a starvation guard and pending-write scoreboard.
module regfile_write_scheduler
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = rf_pkg::DATA_WIDTH,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                        iClk,
    input  logic                        iRstN,
    input  logic                        iWbValid,
    output logic                        oWbReady,
    input  logic [ADDRESS_WIDTH-1:0]    iWbAddr,
    input  logic [DATA_WIDTH-1:0]       iWbData,
    input  logic                        iLlValid,
    output logic                        oLlReady,
    input  logic [ADDRESS_WIDTH-1:0]    iLlAddr,
    input  logic [DATA_WIDTH-1:0]       iLlData,
    input  logic                        iIssueEn,
    input  logic [ADDRESS_WIDTH-1:0]    iIssueRd,
    input  logic [ADDRESS_WIDTH-1:0]    iDecRs1,
    input  logic [ADDRESS_WIDTH-1:0]    iDecRs2,
    input  logic [ADDRESS_WIDTH-1:0]    iDecRd,
    input  logic                        iDecRdUsed,
    output logic                        oStall,
    output logic                        oWriteEn,
    output logic [ADDRESS_WIDTH-1:0]    oWriteAddress,
    output logic [DATA_WIDTH-1:0]       oWriteData,
    output logic [2**ADDRESS_WIDTH-1:0] oPending
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
    } req_t;

    logic             ll_full;
    req_t             ll_buf;
    logic [CNT_W-1:0] starve_cnt;
    logic             ll_win;
    logic             wb_win;
    req_t             win_req;

    // Arbitration: WB has priority until LL has lost STARVE_LIMIT cycles in a row.
    always_comb begin
        ll_win   = ll_full && (!iWbValid || (starve_cnt == CNT_MAX));
        wb_win   = iWbValid && !ll_win;
        win_req  = ll_win ? ll_buf : req_t'{addr: iWbAddr, data: iWbData};
        oLlReady = iRstN && !ll_full;
        oWbReady = iRstN && !(ll_win && iWbValid);
    end

    // One-entry LL buffer: fills on handshake, drains on grant.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            ll_full <= 1'b0;
            ll_buf  <= '0;
        end else if (ll_win) begin
            ll_full <= 1'b0;
        end else if (iLlValid && oLlReady) begin
            ll_full <= 1'b1;
            ll_buf  <= req_t'{addr: iLlAddr, data: iLlData};
        end
    end

    // Starve counter: counts consecutive WB wins while LL waits, saturating.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)                   starve_cnt <= '0;
        else if (!ll_full || ll_win)  starve_cnt <= '0;
        else if (wb_win && (starve_cnt != CNT_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end

    // Write-port register; x0 grants complete the handshake but never assert the enable.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            oWriteEn      <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else begin
            oWriteEn <= (ll_win || wb_win) && (win_req.addr != '0);
            if (ll_win || wb_win) begin
                oWriteAddress <= win_req.addr;
                oWriteData    <= win_req.data;
            end
        end
    end

    rf_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .NUM_REGS      (2**ADDRESS_WIDTH)
    ) u_scoreboard (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iSetEn     (iIssueEn),
        .iSetAddr   (iIssueRd),
        .iClrEn     (ll_win),
        .iClrAddr   (ll_buf.addr),
        .iDecRs1    (iDecRs1),
        .iDecRs2    (iDecRs2),
        .iDecRd     (iDecRd),
        .iDecRdUsed (iDecRdUsed),
        .oStall     (oStall),
        .oPending   (oPending)
    );

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Vector table, hand sequences and a randomized run against a queue-based model.
module tb_regfile_write_scheduler;

    localparam int LIM = 4;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iWbValid, oWbReady, iLlValid, oLlReady;
    logic [4:0]  iWbAddr, iLlAddr, iIssueRd, iDecRs1, iDecRs2, iDecRd;
    logic [31:0] iWbData, iLlData;
    logic        iIssueEn, iDecRdUsed, oStall, oWriteEn;
    logic [4:0]  oWriteAddress;
    logic [31:0] oWriteData, oPending;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        bit wbv; bit [4:0] wba; bit [31:0] wbd;
        bit llv; bit [4:0] lla; bit [31:0] lld;
        bit ise; bit [4:0] isr;
        bit [4:0] rs1, rs2, rd; bit rdu;
        bit wbr, llr, stl, we; bit [4:0] wa; bit [31:0] wd; bit [31:0] pend;
    } vec_t;

    typedef struct { bit [4:0] a; bit [31:0] d; } req_t;

    // reference model state
    req_t     mq[$];
    int       lost;
    bit [31:0] mpend;

    regfile_write_scheduler #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(LIM)) dut (
        .iClk(iClk), .iRstN(iRstN),
        .iWbValid(iWbValid), .oWbReady(oWbReady), .iWbAddr(iWbAddr), .iWbData(iWbData),
        .iLlValid(iLlValid), .oLlReady(oLlReady), .iLlAddr(iLlAddr), .iLlData(iLlData),
        .iIssueEn(iIssueEn), .iIssueRd(iIssueRd),
        .iDecRs1(iDecRs1), .iDecRs2(iDecRs2), .iDecRd(iDecRd), .iDecRdUsed(iDecRdUsed),
        .oStall(oStall), .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress),
        .oWriteData(oWriteData), .oPending(oPending)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t nv();
        vec_t v;
        v = '{default: 0};
        v.wbr = 1'b1; v.llr = 1'b1;
        return v;
    endfunction

    task automatic drive_idle();
        iWbValid = 0; iWbAddr = 0; iWbData = 0; iLlValid = 0; iLlAddr = 0; iLlData = 0;
        iIssueEn = 0; iIssueRd = 0; iDecRs1 = 0; iDecRs2 = 0; iDecRd = 0; iDecRdUsed = 0;
    endtask

    // Drive one cycle: combinational checks before the edge, registered checks after it.
    task automatic apply(input vec_t v, input string tag);
        iWbValid = v.wbv; iWbAddr = v.wba; iWbData = v.wbd;
        iLlValid = v.llv; iLlAddr = v.lla; iLlData = v.lld;
        iIssueEn = v.ise; iIssueRd = v.isr;
        iDecRs1 = v.rs1; iDecRs2 = v.rs2; iDecRd = v.rd; iDecRdUsed = v.rdu;
        #1;
        chk({tag, " wb_ready"}, 64'(oWbReady), 64'(v.wbr));
        chk({tag, " ll_ready"}, 64'(oLlReady), 64'(v.llr));
        chk({tag, " stall"},    64'(oStall),   64'(v.stl));
        @(posedge iClk); #1;
        chk({tag, " write_en"}, 64'(oWriteEn), 64'(v.we));
        if (v.we) begin
            chk({tag, " write_addr"}, 64'(oWriteAddress), 64'(v.wa));
            chk({tag, " write_data"}, 64'(oWriteData),    64'(v.wd));
        end
        chk({tag, " pending"}, 64'(oPending), 64'(v.pend));
    endtask

    // Spec-level model: fills in the expected fields of v and advances one cycle.
    task automatic model(inout vec_t v);
        bit   full, llw;
        req_t r;
        full  = (mq.size() != 0);
        llw   = full && (!v.wbv || lost == LIM);
        v.wbr = !(llw && v.wbv);
        v.llr = !full;
        v.stl = (v.rs1 != 0 && mpend[v.rs1]) || (v.rs2 != 0 && mpend[v.rs2]) ||
                (v.rdu && mpend[v.rd]);
        v.we = 0; v.wa = 0; v.wd = 0;
        if (llw) begin
            r = mq.pop_front();
            v.we = (r.a != 0); v.wa = r.a; v.wd = r.d;
            mpend[r.a] = 1'b0;
            lost = 0;
        end else if (v.wbv) begin
            v.we = (v.wba != 0); v.wa = v.wba; v.wd = v.wbd;
            lost = full ? ((lost + 1 > LIM) ? LIM : lost + 1) : 0;
        end else begin
            lost = 0;
        end
        if (v.llv && !full) begin
            r.a = v.lla; r.d = v.lld;
            mq.push_back(r);
        end
        if (v.ise && v.isr != 0) mpend[v.isr] = 1'b1;
        v.pend = mpend;
    endtask

    task automatic do_reset();
        drive_idle();
        iRstN = 0;
        @(posedge iClk); #1;
        iRstN = 1;
        mq.delete(); lost = 0; mpend = 0;
    endtask

    vec_t tbl[12];

    initial begin
        vec_t v;
        // directed table, applied back to back from reset
        for (int i = 0; i < 12; i++) tbl[i] = nv();
        tbl[0].wbv = 1; tbl[0].wba = 5; tbl[0].wbd = 32'hDEADBEEF;
        tbl[0].we = 1; tbl[0].wa = 5; tbl[0].wd = 32'hDEADBEEF;
        tbl[1].ise = 1; tbl[1].isr = 9; tbl[1].pend = 32'h200;
        tbl[2].rs1 = 9; tbl[2].llv = 1; tbl[2].lla = 9; tbl[2].lld = 32'h99;
        tbl[2].stl = 1; tbl[2].pend = 32'h200;
        tbl[3].rd = 9; tbl[3].rdu = 1; tbl[3].stl = 1; tbl[3].llr = 0;
        tbl[3].we = 1; tbl[3].wa = 9; tbl[3].wd = 32'h99;
        tbl[4].rs2 = 9;
        tbl[5].wbv = 1; tbl[5].wba = 0; tbl[5].wbd = 32'h55;
        tbl[5].llv = 1; tbl[5].lla = 0; tbl[5].lld = 32'h66; tbl[5].ise = 1; tbl[5].isr = 0;
        tbl[6].llr = 0;
        tbl[7].llv = 1; tbl[7].lla = 3; tbl[7].lld = 32'h33; tbl[7].ise = 1; tbl[7].isr = 3;
        tbl[7].pend = 32'h8;
        tbl[8].ise = 1; tbl[8].isr = 3; tbl[8].llr = 0;
        tbl[8].we = 1; tbl[8].wa = 3; tbl[8].wd = 32'h33; tbl[8].pend = 32'h8;
        tbl[9].rs1 = 3; tbl[9].stl = 1; tbl[9].wbv = 1; tbl[9].wba = 10; tbl[9].wbd = 32'hA;
        tbl[9].llv = 1; tbl[9].lla = 11; tbl[9].lld = 32'hB;
        tbl[9].we = 1; tbl[9].wa = 10; tbl[9].wd = 32'hA; tbl[9].pend = 32'h8;
        tbl[10].wbv = 1; tbl[10].wba = 12; tbl[10].wbd = 32'hC; tbl[10].llr = 0;
        tbl[10].we = 1; tbl[10].wa = 12; tbl[10].wd = 32'hC; tbl[10].pend = 32'h8;
        tbl[11].rd = 3; tbl[11].rdu = 0; tbl[11].llr = 0;
        tbl[11].we = 1; tbl[11].wa = 11; tbl[11].wd = 32'hB; tbl[11].pend = 32'h8;

        // reset state
        drive_idle();
        iRstN = 0;
        #3;
        chk("reset write_en", 64'(oWriteEn), 0);
        chk("reset write_addr", 64'(oWriteAddress), 0);
        chk("reset write_data", 64'(oWriteData), 0);
        chk("reset pending", 64'(oPending), 0);
        chk("reset wb_ready", 64'(oWbReady), 0);
        chk("reset ll_ready", 64'(oLlReady), 0);
        @(posedge iClk); #1;
        iRstN = 1;

        for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // starvation: LL buffered while WB hammers the port
        v = nv(); v.llv = 1; v.lla = 7; v.lld = 32'h1234; v.pend = 32'h8;
        apply(v, "starve cap");
        for (int i = 0; i <= LIM; i++) begin
            v = nv(); v.wbv = 1; v.wba = 5'(20 + i); v.wbd = 32'(100 + i);
            v.llr = 0; v.we = 1; v.pend = 32'h8;
            if (i < LIM) begin
                v.wa = 5'(20 + i); v.wd = 32'(100 + i);
            end else begin
                v.wbr = 0; v.wa = 7; v.wd = 32'h1234;
            end
            apply(v, $sformatf("starve[%0d]", i));
        end
        v = nv(); v.wbv = 1; v.wba = 30; v.wbd = 32'h77;
        v.we = 1; v.wa = 30; v.wd = 32'h77; v.pend = 32'h8;
        apply(v, "starve after");

        // reset mid-operation with a buffered LL write and pending bits
        v = nv(); v.ise = 1; v.isr = 4; v.llv = 1; v.lla = 4; v.lld = 32'h44; v.pend = 32'h18;
        apply(v, "midrst setup");
        drive_idle();
        iRstN = 0;
        #1;
        chk("midrst write_en", 64'(oWriteEn), 0);
        chk("midrst write_addr", 64'(oWriteAddress), 0);
        chk("midrst write_data", 64'(oWriteData), 0);
        chk("midrst pending", 64'(oPending), 0);
        chk("midrst wb_ready", 64'(oWbReady), 0);
        chk("midrst ll_ready", 64'(oLlReady), 0);
        @(posedge iClk); #1;
        iRstN = 1;
        apply(nv(), "midrst post0");
        apply(nv(), "midrst post1");

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = nv();
            v.wbv = ($urandom_range(3) != 0); v.wba = 5'($urandom); v.wbd = $urandom;
            v.llv = $urandom_range(1) == 1;   v.lla = 5'($urandom); v.lld = $urandom;
            v.ise = ($urandom_range(3) == 0); v.isr = 5'($urandom);
            v.rs1 = 5'($urandom); v.rs2 = 5'($urandom); v.rd = 5'($urandom);
            v.rdu = $urandom_range(1) == 1;
            model(v);
            apply(v, $sformatf("rand[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Schedules the single write port of the 32x32 integer register file between two producers: in-order pipeline writeback (WB) and a long-latency unit (LL: divider, load miss). Also keeps a pending-write scoreboard for LL destinations and raises a decode stall on RAW/WAW hazards against them. Sits between the writeback stage and the register file write port.

## Interface
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 4, consecutive lost cycles after which LL is force-granted (>=1)
- iClk  in  1  clock, rising edge
- iRstN  in  1  asynchronous active-low reset
- iWbValid / oWbReady  in/out  1  WB write request handshake
- iWbAddr, iWbData  in  ADDRESS_WIDTH / DATA_WIDTH  WB destination and value
- iLlValid / oLlReady  in/out  1  LL write request handshake
- iLlAddr, iLlData  in  ADDRESS_WIDTH / DATA_WIDTH  LL destination and value
- iIssueEn, iIssueRd  in  1 / ADDRESS_WIDTH  an LL instruction issues, marking rd pending
- iDecRs1, iDecRs2, iDecRd  in  ADDRESS_WIDTH  operands and destination of instruction in decode
- iDecRdUsed  in  1  decode instruction writes a register
- oStall  out  1  decode must hold
- oWriteEn, oWriteAddress, oWriteData  out  1 / ADDRESS_WIDTH / DATA_WIDTH  register file write port
- oPending  out  2**ADDRESS_WIDTH  scoreboard vector (debug)

## Operation
- Reset: asynchronous and active-low; all outputs and state 0 (oWriteEn=0, oWriteAddress=0, oWriteData=0, oPending=0, oWbReady=0 while iRstN low, oLlReady=1 after release, starve counter 0, LL buffer empty).
- LL buffer: one entry. oLlReady = buffer empty. iLlValid&oLlReady captures addr/data next edge.
- Arbitration each cycle, candidates: WB (iWbValid) and LL (buffer full).
  - Only one present: it wins.
  - Both present: WB wins unless starve counter == STARVE_LIMIT, then LL wins.
  - oWbReady = 1 except when LL wins over a valid WB (combinational from buffer state and counter).
- Starve counter: +1 each cycle LL buffer full and WB wins; clears to 0 when LL wins or buffer empty; saturates at STARVE_LIMIT.
- Winner's addr/data registered onto write port; oWriteEn=1 next cycle, except address 0: consumed (handshake completes, buffer frees) but oWriteEn=0.
- Scoreboard: iIssueEn with iIssueRd!=0 sets pending[rd] next edge. LL grant clears pending[addr]. Same rd set and cleared same cycle: set wins. pending[0] always 0.
- oStall = iDecRs1/Rs2 nonzero and pending, or iDecRdUsed and pending[iDecRd] (WAW). Combinational from registered scoreboard; guarantees WB and LL never target the same register concurrently.
- LL write to a non-pending register: still written, no error.

## Timing
- WB accepted at edge N -> oWriteEn high cycle N+1 (1-cycle latency).
- LL captured at edge N -> earliest grant cycle N+1 -> write port cycle N+2; buffer free (oLlReady=1) cycle N+2.
- Pending bit clears at the same edge the LL write is registered; oStall for that rd drops in the cycle oWriteEn is high (register file internally forwards the written value).
- Worst-case LL wait with continuous WB: STARVE_LIMIT cycles, then forced grant; WB stalls exactly one cycle.
- Reset asserted mid-operation: buffered LL write and pending bits discarded; no write issued.

## Structure
- Shared package rf_pkg: ADDRESS_WIDTH/DATA_WIDTH constants, rf_wr_req_t struct {addr, data}, REG_ZERO constant.
- Sub-module rf_scoreboard (pending vector, set/clear, hazard compare); arbitration, starve counter, LL buffer and write-port register in the top.

## Test plan
- WB only: iWbValid=1, addr 5, data 0xDEADBEEF -> next cycle oWriteEn=1, oWriteAddress=5, oWriteData=0xDEADBEEF; oWbReady stays 1.
- Starvation: LL buffered (addr 7, 0x1234), WB valid every cycle, STARVE_LIMIT=4 -> WB wins 4 cycles, cycle 5 oWbReady=0 and LL written to x7 next cycle, counter back to 0.
- Scoreboard: issue rd=9; decode rs1=9 -> oStall=1 until the LL write of x9 reaches the port, then 0; decode rd=9 also stalls (WAW).
- x0: WB and LL writes to addr 0 -> handshakes complete, oWriteEn never 1; issue rd=0 leaves oPending=0.
- Set/clear collision: LL grant for x3 same cycle as iIssueEn rd=3 -> pending[3]=1 afterwards.
- Reset mid-operation: LL buffered and pending[4]=1, pulse iRstN low -> all outputs 0, oPending=0, buffered write never appears.
